// File: rtl/muldiv_seq_if.sv
// Bus for the iterative mul/div sequencer: request/result side plus
// the shared-ALU borrow handshake (slave = sequencer, master = core).
interface muldiv_seq_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        alu_req;
  logic        alu_gnt;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_carryout;

  modport slave (
    input  start, op, a, b,
    input  alu_gnt, alu_result, alu_carryout,
    output busy, done, hi, lo,
    output alu_req, alu_A, alu_B, alu_op
  );

  modport master (
    output start, op, a, b,
    output alu_gnt, alu_result, alu_carryout,
    input  busy, done, hi, lo,
    input  alu_req, alu_A, alu_B, alu_op
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative 32-bit MULT[U]/DIV[U] into HI/LO using the shared core ALU.
// Ports: clk, resetn (async low), bus (muldiv_seq_if.slave).
// Macro MULDIV_SIGNED_EN adds signed ops (op[1]) and a FIX state.
module muldiv_seq (
  input logic         clk,
  input logic         resetn,
  muldiv_seq_if.slave bus
);
  localparam int         ITER   = 32;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;

`ifdef MULDIV_SIGNED_EN
  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_FIX, S_DONE
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DONE
  } state_e;
`endif

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] mb_q, mb_d;
  logic        div_q, div_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        req_q, req_d;

`ifdef MULDIV_SIGNED_EN
  logic        fix_q, fix_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic        sa, sb;
`else
  logic        unused_op1;
`endif

  logic [31:0] opa, opb;
  logic [31:0] shl;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;

  // Restoring-divide partial remainder shifted left by one.
  assign shl = {hi_q[30:0], lo_q[31]};

`ifdef MULDIV_SIGNED_EN
  always_comb begin
    sa  = bus.op[1] & bus.a[31];
    sb  = bus.op[1] & bus.b[31];
    opa = sa ? (~bus.a + 32'd1) : bus.a;
    opb = sb ? (~bus.b + 32'd1) : bus.b;
  end
`else
  assign opa        = bus.a;
  assign opb        = bus.b;
  assign unused_op1 = bus.op[1];
`endif

  // Pending ALU operation; held even while the grant is withheld.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = 3'b000;
    if (state_q == S_RUN) begin
      if (div_q) begin
        alu_a  = shl;
        alu_b  = mb_q;
        alu_op = OP_SUB;
      end else begin
        alu_a  = hi_q;
        alu_b  = lo_q[0] ? mb_q : 32'd0;
        alu_op = OP_ADD;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mb_d    = mb_q;
    div_d   = div_q;
`ifdef MULDIV_SIGNED_EN
    fix_d   = fix_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cnt_d   = '0;
          hi_d    = '0;
          div_d   = bus.op[0];
          lo_d    = bus.op[0] ? opa : opb;
          mb_d    = bus.op[0] ? opb : opa;
`ifdef MULDIV_SIGNED_EN
          fix_d   = bus.op[1];
          qneg_d  = sa ^ sb;
          rneg_d  = sa;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.alu_gnt) begin
          cnt_d = cnt_q + 6'd1;
          if (div_q) begin
            // Borrow clear (or a lost top bit) means it fits.
            if (hi_q[31] | ~bus.alu_carryout) begin
              hi_d = bus.alu_result;
              lo_d = {lo_q[30:0], 1'b1};
            end else begin
              hi_d = shl;
              lo_d = {lo_q[30:0], 1'b0};
            end
          end else begin
            hi_d = {bus.alu_carryout, bus.alu_result[31:1]};
            lo_d = {bus.alu_result[0], lo_q[31:1]};
          end
          if (cnt_q == 6'(ITER - 1)) begin
`ifdef MULDIV_SIGNED_EN
            state_d = fix_q ? S_FIX : S_DONE;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef MULDIV_SIGNED_EN
      S_FIX: begin
        if (div_q) begin
          if (qneg_q) lo_d = ~lo_q + 32'd1;
          if (rneg_q) hi_d = ~hi_q + 32'd1;
        end else if (qneg_q) begin
          {hi_d, lo_d} = ~{hi_q, lo_q} + 64'd1;
        end
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    req_d  = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mb_q    <= '0;
      div_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      fix_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mb_q    <= mb_d;
      div_q   <= div_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
`ifdef MULDIV_SIGNED_EN
      fix_q   <= fix_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.alu_req = req_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.alu_A   = alu_a;
  assign bus.alu_B   = alu_b;
  assign bus.alu_op  = alu_op;
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: shared-ALU model, arithmetic reference model,
// directed literal cases and randomized start/grant traffic.
module tb_muldiv_seq;
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_BUILD = 1'b1;
`else
  localparam bit SIGNED_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  muldiv_seq_if bus();

  muldiv_seq dut (
    .clk    (clk),
    .resetn (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU: 33-bit add/sub, bit 32 is carry (add) or borrow (sub).
  logic [32:0] alu_sum;
  always_comb begin
    if (bus.alu_op == 3'b110)
      alu_sum = {1'b0, bus.alu_A} - {1'b0, bus.alu_B};
    else
      alu_sum = {1'b0, bus.alu_A} + {1'b0, bus.alu_B};
  end
  assign bus.alu_result   = alu_sum[31:0];
  assign bus.alu_carryout = alu_sum[32];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // {hi, lo} from plain arithmetic on magnitudes and signs.
  function automatic logic [63:0] ref_res(logic [1:0] op,
                                          logic [31:0] a,
                                          logic [31:0] b);
    logic        sg;
    logic [31:0] ma, mb, q, r;
    logic [63:0] p;
    sg = SIGNED_BUILD && op[1];
    ma = (sg && a[31]) ? 32'(-a) : a;
    mb = (sg && b[31]) ? 32'(-b) : b;
    if (!op[0]) begin
      p = {32'd0, ma} * {32'd0, mb};
      if (sg && (a[31] ^ b[31])) p = -p;
      return p;
    end
    if (mb == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = ma;
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    if (sg && (a[31] ^ b[31])) q = -q;
    if (sg && a[31]) r = -r;
    return {r, q};
  endfunction

  // Model: grants still owed, cycles of sign fix-up after them,
  // and whether done is due in the coming cycle.
  int          m_left, m_post;
  bit          m_done, m_div;
  logic [31:0] e_hi, e_lo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_post = 0;
      m_done = 0;
      m_div  = 0;
      e_hi   = '0;
      e_lo   = '0;
    end else begin
      bit          was_done;
      logic [63:0] r;
      was_done = m_done;
      m_done   = 0;
      if (m_left > 0) begin
        if (bus.alu_gnt) begin
          m_left--;
          if (m_left == 0 && m_post == 0) m_done = 1;
        end
      end else if (m_post > 0) begin
        m_post--;
        if (m_post == 0) m_done = 1;
      end else if (!was_done && bus.start) begin
        m_left = 32;
        m_div  = bus.op[0];
        m_post = (SIGNED_BUILD && bus.op[1]) ? 1 : 0;
        r      = ref_res(bus.op, bus.a, bus.b);
        e_hi   = r[63:32];
        e_lo   = r[31:0];
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      bit run, busy_e;
      run    = (m_left > 0);
      busy_e = run || (m_post > 0) || m_done;
      chk("busy", 32'(bus.busy), 32'(busy_e));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("alu_req", 32'(bus.alu_req), 32'(run));
      chk("alu_op", 32'(bus.alu_op),
          run ? (m_div ? 32'd6 : 32'd2) : 32'd0);
      if (!run) begin
        chk("alu_A_idle", bus.alu_A, 32'd0);
        chk("alu_B_idle", bus.alu_B, 32'd0);
        if (m_post == 0) begin
          chk("hi", bus.hi, e_hi);
          chk("lo", bus.lo, e_lo);
        end
      end
    end
  end

  // mode 0: grant every cycle; 1: grant on odd cycles.
  // inj: cycle on which a stray start pulse is driven (0 = none).
  task automatic run_op(string nm, logic [1:0] op,
                        logic [31:0] a, logic [31:0] b,
                        int mode, int inj,
                        logic [31:0] eh, logic [31:0] el, int elat);
    int k;
    bit seen;
    @(negedge clk);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    k    = 0;
    seen = 0;
    while (!seen && k < 200) begin
      bus.alu_gnt = (mode == 0) || ((k + 1) % 2 == 1);
      bus.start   = (inj != 0) && (k + 1 == inj);
      if (bus.start) begin
        bus.a  = ~a;
        bus.b  = b + 32'd1;
        bus.op = ~op;
      end else begin
        bus.a  = a;
        bus.b  = b;
        bus.op = op;
      end
      @(posedge clk);
      k++;
      @(negedge clk);
      seen = bus.done;
    end
    bus.start = 1'b0;
    chk({nm, "_seen_done"}, 32'(seen), 32'd1);
    chk({nm, "_latency"}, 32'(k + 1), 32'(elat));
    chk({nm, "_hi"}, bus.hi, eh);
    chk({nm, "_lo"}, bus.lo, el);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.a       = '0;
    bus.b       = '0;
    bus.alu_gnt = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_req", 32'(bus.alu_req), 32'd0);
    chk("rst_op", 32'(bus.alu_op), 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    run_op("mul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           0, 0, 32'hFFFF_FFFE, 32'h0000_0001, 33);
    run_op("div_100_7", 2'b01, 32'd100, 32'd7,
           0, 0, 32'd2, 32'd14, 33);
    run_op("div_by_0", 2'b01, 32'h1234_5678, 32'd0,
           0, 0, 32'h1234_5678, 32'hFFFF_FFFF, 33);
    run_op("mul_toggle", 2'b00, 32'd3, 32'd5,
           1, 0, 32'd0, 32'd15, 64);
    run_op("div_stray_start", 2'b01, 32'd1000, 32'd10,
           0, 5, 32'd0, 32'd100, 33);

    // Abort a divide mid-run with an asynchronous reset.
    @(negedge clk);
    bus.op    = 2'b01;
    bus.a     = 32'hFFFF_FFFF;
    bus.b     = 32'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.alu_gnt = 1'b1;
    repeat (9) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_req", 32'(bus.alu_req), 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    chk("abort_alu_A", bus.alu_A, 32'd0);
    chk("abort_alu_op", 32'(bus.alu_op), 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    run_op("mul_after_rst", 2'b00, 32'd6, 32'd7,
           0, 0, 32'd0, 32'd42, 33);
`ifdef MULDIV_SIGNED_EN
    run_op("sdiv_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2,
           0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
    run_op("smul_m3_5", 2'b10, 32'hFFFF_FFFD, 32'd5,
           0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 34);
`else
    run_op("op1_ignored", 2'b11, 32'hFFFF_FFF9, 32'd2,
           0, 0, 32'd1, 32'h7FFF_FFFC, 33);
`endif

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      bus.start   = ($urandom_range(0, 4) == 0);
      bus.op      = 2'($urandom);
      bus.a       = pick();
      bus.b       = pick();
      bus.alu_gnt = ($urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    bus.start   = 1'b0;
    bus.alu_gnt = 1'b1;
    for (int i = 0; i < 80 && bus.busy; i++) @(negedge clk);
    chk("drain_idle", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative 32-bit multiply/divide sequencer for the multi-cycle MIPS core (MULT[U]/DIV[U] into HI/LO). It owns no adder; it borrows the shared ALU through a req/gnt handshake and issues one add (ALUop 010) or subtract (ALUop 110) per granted cycle. Products and quotients therefore come from the same datapath adder the core already uses. The core's ALU input mux selects this block's operands whenever alu_gnt is high.

Parameters:
ITER, 32, iteration count; fixed to operand width, not user-tunable.

Ports:
clk  input  1  core clock
resetn  input  1  reset; asynchronous, active-low
start  input  1  launch request; sampled only in IDLE
op  input  2  op[0]: 0=multiply, 1=divide; op[1]: signed (see Optional Feature)
a  input  32  multiplicand / dividend
b  input  32  multiplier / divisor
busy  output  1  high from the cycle after start acceptance until done
done  output  1  one-cycle pulse; hi/lo valid
hi  output  32  product[63:32] / remainder
lo  output  32  product[31:0] / quotient
alu_req  output  1  high in RUN
alu_gnt  input  1  ALU granted this cycle
alu_A  output  32  shared ALU operand A
alu_B  output  32  shared ALU operand B
alu_op  output  3  shared ALU opcode (010 add, 110 sub)
alu_result  input  32  ALU Result (combinational, same cycle)
alu_carryout  input  1  ALU CarryOut; on 010 = unsigned carry, on 110 = borrow (A<B unsigned)

Behaviour:
- Reset (async, resetn=0): state=IDLE; busy, done, alu_req = 0; hi, lo, alu_A, alu_B = 0; alu_op = 000; counter = 0. Asserting resetn low mid-operation aborts the operation immediately; no done is produced.
- FSM states: IDLE, RUN, (FIX if macro defined), DONE.
  - IDLE: if start, latch operands, counter=0, go RUN. Multiply: lo=b, hi=0, mcand=a. Divide: lo=a, hi=0, divisor=b.
  - RUN: alu_req=1. Each cycle with alu_gnt=1 executes one iteration and increments counter. Cycles with alu_gnt=0 hold all state, and alu_A/alu_B/alu_op still drive the pending operation.
    - After iteration 32: go DONE, or FIX for signed ops.
  - DONE: done=1 for one cycle, then IDLE.
- Outside RUN: alu_req=0, alu_A=alu_B=0, alu_op=000.
- Multiply iteration:
  - alu_A=hi; alu_B = lo[0] ? mcand : 0; alu_op=010.
  - Next hi = {alu_carryout, alu_result[31:1]}; next lo = {alu_result[0], lo[31:1]}.
- Divide iteration (restoring):
  - s = {hi[30:0], lo[31]}; m = hi[31].
  - alu_A=s; alu_B=divisor; alu_op=110.
  - If m | ~alu_carryout: hi=alu_result, qbit=1. Else: hi=s, qbit=0.
  - lo = {lo[30:0], qbit}.
- Divide by zero: no special case. The algorithm yields hi=a, lo=0xFFFFFFFF at normal latency.
- Latency with alu_gnt held high: start accepted at cycle 0, done at cycle 33. In general, done comes one cycle after the 32nd granted cycle.
- start while busy or in DONE: ignored.
- hi/lo hold their final value after done until the next accepted start. Intermediate values are visible during RUN and must not be consumed.

Optional Feature:
MULDIV_SIGNED_EN.
- Defined, op[1]=1 (signed):
  - At start, operands are replaced by their magnitudes via local two's-complement logic (no ALU use); operand signs are recorded.
  - After RUN, a 1-cycle FIX state applies sign correction:
    - Multiply: 64-bit product negated if the operand signs differ.
    - Divide: quotient negated if the operand signs differ; remainder takes the sign of the dividend.
  - Signed latency is 34 cycles; unsigned stays at 33.
- Not defined: op[1] is ignored, all operations are unsigned, and the FIX state does not exist.

Test Plan:
- Multiply, a=b=0xFFFFFFFF, alu_gnt=1 -> done at cycle 33, hi=0xFFFFFFFE, lo=0x00000001; busy high for cycles 1-33, low otherwise.
- Divide, a=100, b=7 -> lo=14, hi=2; alu_op=110 on every RUN cycle.
- Divide, a=0x12345678, b=0 -> hi=0x12345678, lo=0xFFFFFFFF, done at cycle 33.
- Multiply, a=3, b=5, with alu_gnt toggling 1,0,1,0 -> done exactly one cycle after the 32nd granted cycle; hi=0, lo=15; state frozen on gnt=0 cycles.
- Start a divide, pull resetn low at cycle 10 -> all outputs zero asynchronously, no done; a new start after release completes normally. A start pulse during RUN -> ignored.
- With MULDIV_SIGNED_EN:
  - signed divide -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - signed multiply -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1, done at cycle 34.
